window_extrema_filter: RTL
==========================

// Module: window_extrema_filter
// PURPOSE
//   Multi-channel windowed filter for slow sensor/ADC samples (phase current, bus voltage) on the 1 kHz domain.
//   Each channel reduces a window of 2**WIN_LOG2 accepted samples to one result: min, max, mean or peak-to-peak.
//   Mode is selectable at runtime. One result vector is published per window.
//   Sits between the sampled ADC data bus and the BLDC control/protection logic.
// PARAMETERS
//   DATA_WIDTH  10  width of one channel sample and one channel result (unsigned)
//   NUM_CH      2   number of independent channels, processed in parallel (>=1)
//   WIN_LOG2    10  log2 of window length; window = 2**WIN_LOG2 accepted samples (>=1)
// PORTS
//   clock_1khz    in   1                  filter clock
//   rst           in   1                  reset, asynchronous, active-high
//   clear         in   1                  sync restart of current window; published outputs held
//   mode          in   2                  0=min 1=max 2=mean 3=peak-to-peak (max-min)
//   sample_valid  in   1                  datain accepted on a rising edge when high
//   datain        in   NUM_CH*DATA_WIDTH  channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_filter   out  NUM_CH*DATA_WIDTH  last published result per channel, same packing
//   out_valid     out  1                  one-cycle pulse: new data_filter published
//   sample_cnt    out  WIN_LOG2           accepted samples so far in current window
// BEHAVIOUR
//   Reset (async): data_filter=0, out_valid=0, sample_cnt=0, all accumulators 0, mode_q=0.
//   Per-channel state: run_min, run_max (DATA_WIDTH), run_sum (DATA_WIDTH+WIN_LOG2, no overflow possible).
//   Accept edge (sample_valid=1, clear=0):
//   - sample_cnt==0: load run_min=run_max=run_sum=sample; latch mode_q<=mode.
//   - otherwise: run_min=min(run_min,sample), run_max=max(run_max,sample), run_sum+=sample.
//   - Ties (sample equal to run_min/run_max) leave the value unchanged.
//   - sample_cnt increments; wraps to 0 after 2**WIN_LOG2-1.
//   Publish: on the accept edge where sample_cnt==2**WIN_LOG2-1:
//   - data_filter is loaded with the result including that final sample, for every channel.
//   - out_valid=1 for exactly the following cycle. Latency: 0 edges after the last sample.
//   Results by mode_q:
//   - min/max: run values.
//   - mean: (run_sum+sample) >> WIN_LOG2, truncating (no rounding).
//   - p2p: max-min, always >= 0.
//   Mode changes mid-window are ignored until the next window start (mode_q latched at sample 0).
//   sample_valid=0: no state change; out_valid=0; data_filter holds.
//   clear=1 (sync):
//   - sample_cnt<=0; accumulators are don't-care (reloaded on the next sample); out_valid<=0.
//   - data_filter holds. Clear wins over a simultaneous sample_valid: that sample is dropped.
//   - clear on the would-be publish edge: no publish.
//   Back-to-back windows: the sample after a publish edge is sample 0 of the next window; no dead cycle.
//   rst mid-window: everything returns to reset values immediately; a partial window is discarded.
//   Channels are fully independent except the shared sample_cnt, mode_q and out_valid.
// TESTING (DATA_WIDTH=10, NUM_CH=2, WIN_LOG2=2)
//   1. Reset values:
//      - rst pulse -> data_filter=0, out_valid=0, sample_cnt=0.
//   2. One window per mode:
//      - stimulus: ch0 = 5,3,9,7 and ch1 = 1023,0,512,1.
//      - mode 0 -> {ch1=0,    ch0=3}, out_valid single pulse after 4th sample.
//      - mode 1 -> {ch1=1023, ch0=9}.
//      - mode 2 -> {ch1=384,  ch0=6}  (1536>>2, 24>>2).
//      - mode 3 -> {ch1=1023, ch0=6}.
//   3. Gaps and mode latching:
//      - sample_valid gaps between samples -> same results; out_valid never high between windows.
//      - mode switched 0->1 after sample 1 -> window still yields min; next window yields max.
//   4. Clear:
//      - clear after 2 samples -> sample_cnt=0, data_filter unchanged, next 4 samples form a full window.
//      - clear with sample_valid on the 4th sample -> no out_valid, sample_cnt=0.
//   5. Mean at full scale:
//      - 4 samples of 1023 in mode 2 -> 1023 (no sum overflow).
//      - samples 1,1,1,2 -> 1 (truncation).
//   6. Async reset and back-to-back windows:
//      - async rst asserted between edges mid-window -> outputs 0 immediately.
//      - 8 consecutive valid samples -> two out_valid pulses exactly 4 cycles apart.

Source files
------------

// File: rtl/window_extrema_filter_if.sv
// Bundle between the sampled ADC data bus and the windowed extrema filter.
// The master side drives the window controls and the samples. The slave side
// (the filter) returns the published per-channel results, the publish strobe
// and the current window fill level.
//   clear        restart the current window; published results are kept
//   mode         0=min 1=max 2=mean 3=peak-to-peak
//   sample_valid datain is taken on this clock edge
//   datain       channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   data_filter  last published result per channel, same packing as datain
//   out_valid    one-cycle strobe: data_filter has just been updated
//   sample_cnt   samples accepted so far in the current window
interface window_extrema_filter_if #(
   parameter int DATA_WIDTH = 10,
   parameter int NUM_CH     = 2,
   parameter int WIN_LOG2   = 10
);
   logic                           clear;
   logic [1:0]                     mode;
   logic                           sample_valid;
   logic [NUM_CH*DATA_WIDTH-1:0]   datain;
   logic [NUM_CH*DATA_WIDTH-1:0]   data_filter;
   logic                           out_valid;
   logic [WIN_LOG2-1:0]            sample_cnt;

   modport master (
      output clear, mode, sample_valid, datain,
      input  data_filter, out_valid, sample_cnt
   );

   modport slave (
      input  clear, mode, sample_valid, datain,
      output data_filter, out_valid, sample_cnt
   );
endinterface

// File: rtl/window_extrema_filter.sv
// Multi-channel windowed reduction of slow ADC samples (1 kHz domain).
// Each channel folds 2**WIN_LOG2 accepted samples into one result: min, max,
// truncated mean or peak-to-peak. The mode is latched at the first sample of
// each window. One result vector is published per window, on the same edge
// that accepts the final sample.
// Ports:
//   clock_1khz  filter clock
//   rst         asynchronous active-high reset
//   bus         window_extrema_filter_if slave (controls, samples, results)
module window_extrema_filter #(
   parameter int DATA_WIDTH = 10,
   parameter int NUM_CH     = 2,
   parameter int WIN_LOG2   = 10
) (
   input  logic                    clock_1khz,
   input  logic                    rst,
   window_extrema_filter_if.slave  bus
);

   localparam int SUM_W = DATA_WIDTH + WIN_LOG2;
   localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;
   localparam logic [WIN_LOG2-1:0] CNT_ONE  = WIN_LOG2'(1);

   typedef logic [DATA_WIDTH-1:0] data_t;
   typedef logic [SUM_W-1:0]      sum_t;
   typedef enum logic [1:0] {
      MODE_MIN  = 2'd0,
      MODE_MAX  = 2'd1,
      MODE_MEAN = 2'd2,
      MODE_P2P  = 2'd3
   } mode_e;

   logic [WIN_LOG2-1:0]          cnt_q, cnt_d;
   mode_e                        mode_q, mode_d;
   data_t                        run_min_q [NUM_CH];
   data_t                        run_min_d [NUM_CH];
   data_t                        run_max_q [NUM_CH];
   data_t                        run_max_d [NUM_CH];
   sum_t                         run_sum_q [NUM_CH];
   sum_t                         run_sum_d [NUM_CH];
   data_t                        sample_w  [NUM_CH];
   logic [NUM_CH*DATA_WIDTH-1:0] data_filter_q, data_filter_d;
   logic                         out_valid_q, out_valid_d;

   // The sum holds exactly 2**WIN_LOG2 samples, so the mean is simply its
   // top DATA_WIDTH bits (truncating shift).
   function automatic data_t mean_trunc(input sum_t s);
      return s[SUM_W-1 -: DATA_WIDTH];
   endfunction

   function automatic data_t reduce(input mode_e m, input data_t mn,
                                    input data_t mx, input sum_t s);
      case (m)
         MODE_MIN:  return mn;
         MODE_MAX:  return mx;
         MODE_MEAN: return mean_trunc(s);
         default:   return mx - mn;   // max >= min always, no wrap
      endcase
   endfunction

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         sample_w[k] = bus.datain[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      cnt_d         = cnt_q;
      mode_d        = mode_q;
      data_filter_d = data_filter_q;
      out_valid_d   = 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
         run_min_d[k] = run_min_q[k];
         run_max_d[k] = run_max_q[k];
         run_sum_d[k] = run_sum_q[k];
      end

      // Clear dominates: a sample on the same edge is dropped and a pending
      // publish is cancelled. Accumulators are reloaded by the next sample 0.
      if (bus.clear) begin
         cnt_d = '0;
      end else if (bus.sample_valid) begin
         cnt_d = cnt_q + CNT_ONE;
         if (cnt_q == '0) begin
            mode_d = mode_e'(bus.mode);
            for (int k = 0; k < NUM_CH; k++) begin
               run_min_d[k] = sample_w[k];
               run_max_d[k] = sample_w[k];
               run_sum_d[k] = SUM_W'(sample_w[k]);
            end
         end else begin
            for (int k = 0; k < NUM_CH; k++) begin
               if (sample_w[k] < run_min_q[k]) run_min_d[k] = sample_w[k];
               if (sample_w[k] > run_max_q[k]) run_max_d[k] = sample_w[k];
               run_sum_d[k] = run_sum_q[k] + SUM_W'(sample_w[k]);
            end
         end
         // Publish from the updated running values so the final sample is
         // included without an extra cycle. cnt_q is never 0 here, so mode_q
         // already holds this window's mode.
         if (cnt_q == CNT_LAST) begin
            out_valid_d = 1'b1;
            for (int k = 0; k < NUM_CH; k++) begin
               data_filter_d[k*DATA_WIDTH +: DATA_WIDTH] =
                  reduce(mode_q, run_min_d[k], run_max_d[k], run_sum_d[k]);
            end
         end
      end
   end

   always_ff @(posedge clock_1khz or posedge rst) begin
      if (rst) begin
         cnt_q         <= '0;
         mode_q        <= MODE_MIN;
         data_filter_q <= '0;
         out_valid_q   <= 1'b0;
         for (int k = 0; k < NUM_CH; k++) begin
            run_min_q[k] <= '0;
            run_max_q[k] <= '0;
            run_sum_q[k] <= '0;
         end
      end else begin
         cnt_q         <= cnt_d;
         mode_q        <= mode_d;
         data_filter_q <= data_filter_d;
         out_valid_q   <= out_valid_d;
         for (int k = 0; k < NUM_CH; k++) begin
            run_min_q[k] <= run_min_d[k];
            run_max_q[k] <= run_max_d[k];
            run_sum_q[k] <= run_sum_d[k];
         end
      end
   end

   assign bus.data_filter = data_filter_q;
   assign bus.out_valid   = out_valid_q;
   assign bus.sample_cnt  = cnt_q;

endmodule
